sr_rand_gen: RTL and testbench
==============================

Name: sr_rand_gen

Overview:
- Random-bit source feeding the rand_in operand of the stochastic rounding stage. Each word is num_round_bits wide.
- Generates words from a Galois LFSR that advances one bit per cycle. Completed words are buffered in a 2-entry FIFO.
- Words are delivered to the rounding consumer over a valid/ready handshake.
- Software or a test bench can reseed the generator at any time.

Parameters:
- num_round_bits, 4, width of each random word (must be ≥1 and ≤ lfsr_width).
- lfsr_width, 32, LFSR state width.
- lfsr_taps, 32'h80200003, Galois feedback mask (maximal-length for 32 bits).
- reset_seed, 32'h00000001, state loaded on reset (must be nonzero).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  when high, the LFSR may advance; when low, the LFSR and gather logic freeze.
- seed_valid  input  1  one-cycle request to load seed.
- seed  input  lfsr_width  new LFSR state.
- rand_valid  output  1  the FIFO head holds a word.
- rand_ready  input  1  the consumer accepts the head word when it is high together with rand_valid.
- rand_out  output  num_round_bits  FIFO head word; all zeros when the FIFO is empty.
- fill_level  output  2  FIFO occupancy, 0..2.

Behaviour:
- Reset (async assert, sync use on deassert):
  - lfsr = reset_seed; gather = 0; bit count = 0; state = FILL.
  - FIFO empty; rand_valid = 0; rand_out = 0; fill_level = 0.
- LFSR step:
  - lsb = lfsr[0]; lfsr_next = (lfsr >> 1) ^ (lsb ? lfsr_taps : 0).
  - The output bit is lsb. It enters gather at the MSB: gather_next = {lsb, gather[num_round_bits-1:1]}.
  - The first generated bit therefore ends up in the LSB of the word.
- State FILL:
  - When enable=1, one step per cycle and the bit count increments.
  - On the num_round_bits-th step, the completed word (gather_next) is pushed into the FIFO on the same edge and the count resets to 0.
  - If the FIFO would be full after that edge, the word instead stays in gather and the state goes to HOLD.
- State HOLD:
  - No LFSR steps.
  - The held word is pushed on the first edge where FIFO space exists, including an edge with a pop from a full FIFO (simultaneous pop and push at full is legal).
  - The state then returns to FILL with count 0.
- enable=0: LFSR, count and state are frozen. The FIFO can still be popped, and a held word can still be pushed from HOLD.
- FIFO:
  - Pop occurs when rand_valid & rand_ready.
  - Push and pop on the same edge leave fill_level unchanged.
  - rand_valid = (fill_level != 0).
  - rand_out is stable while rand_valid=1 and rand_ready=0.
  - rand_ready while the FIFO is empty is ignored.
- Seed load (seed_valid=1, priority over everything):
  - lfsr = seed, or 1 if seed == 0 (the all-zero lockup state is forbidden).
  - gather, count and FIFO are cleared; state = FILL; any pop in that cycle is discarded.
  - seed_valid overrides enable.
- Latency:
  - From the seed edge with enable held high, the first word is pushed on the num_round_bits-th following edge.
  - rand_valid rises in the cycle after that edge.
  - In steady state, one word is produced per num_round_bits cycles.
- The consumer pops at most once per cycle, so throughput is limited by the LFSR rate, not the handshake.

Test Plan:
- Reset, then seed_valid with seed=1, num_round_bits=4, enable=1, rand_ready=0:
  - 4 edges after the seed, rand_valid=1 and rand_out=4'hB.
  - Internal lfsr after the 4th step is 32'hB02C0003.
- Continue with rand_ready=0:
  - fill_level reaches 2 after 8 steps, then the state is HOLD and the LFSR stops.
  - rand_out stays 4'hB.
- From HOLD, pulse rand_ready for one cycle:
  - A pop and a push occur on the same edge; fill_level stays 2.
  - The state returns to FILL; the next head is the second word.
- seed_valid with seed=0 while the FIFO is full and rand_ready=1:
  - The FIFO is flushed and fill_level=0.
  - The sequence restarts exactly as in the first scenario (first word 4'hB).
- Toggle enable low for 3 cycles mid-word:
  - The word completes 3 cycles later than it would with enable held high.
  - Its value is identical to the value with enable high.
- Assert rst asynchronously while rand_valid=1:
  - rand_valid, rand_out and fill_level go to 0 immediately, without waiting for a clock edge.
  - After release, the first word matches the reset_seed sequence (4'hB for the default seed).

Source files
------------

// File: rtl/sr_rand_gen.sv
// sr_rand_gen: Galois-LFSR random word source with a 2-entry valid/ready output FIFO
module sr_rand_gen #(
   parameter int num_round_bits = 4,
   parameter int lfsr_width = 32,
   parameter logic [lfsr_width-1:0] lfsr_taps = 32'h80200003,
   parameter logic [lfsr_width-1:0] reset_seed = 32'h00000001
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic                      seed_valid,
   input  logic [lfsr_width-1:0]     seed,
   output logic                      rand_valid,
   input  logic                      rand_ready,
   output logic [num_round_bits-1:0] rand_out,
   output logic [1:0]                fill_level
);
   localparam int cw = num_round_bits > 1 ? $clog2(num_round_bits) : 1;
   localparam logic [cw-1:0] last = cw'(num_round_bits - 1);
   typedef enum logic {FILL, HOLD} state_t;
   state_t state, state_next;
   logic [lfsr_width-1:0] lfsr, lfsr_step;
   logic [num_round_bits-1:0] gather, gather_step, push_data;
   logic [num_round_bits-1:0] mem [2];
   logic [cw-1:0] count;
   logic rd_ptr, wr_ptr, step, word_done, space, push, pop;

   assign lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? lfsr_taps : '0);
   generate
      if (num_round_bits == 1) begin : g_one
         assign gather_step = lfsr[0];
      end else begin : g_wide
         assign gather_step = {lfsr[0], gather[num_round_bits-1:1]};
      end
   endgenerate

   assign pop = rand_valid & rand_ready;
   assign space = (fill_level != 2'd2) | pop;
   assign rand_valid = fill_level != 2'd0;
   assign rand_out = rand_valid ? mem[rd_ptr] : '0;

   // FSM state register; a seed load always restarts gathering
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= FILL;
      else state <= seed_valid ? FILL : state_next;

   // a completed word with no FIFO room parks in HOLD until space appears
   always_comb
      state_next = (state == HOLD) ? (space ? FILL : HOLD) : ((word_done & ~space) ? HOLD : FILL);

   // FSM outputs: LFSR stepping and FIFO push control
   always_comb begin
      step = (state == FILL) & enable;
      word_done = step & (count == last);
      push = (state == HOLD) ? space : (word_done & space);
      push_data = (state == HOLD) ? gather : gather_step;
   end

   // LFSR, gather shift register and bit counter; zero seed maps to 1 to avoid lockup
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         lfsr <= reset_seed;
         gather <= '0;
         count <= '0;
      end else if (seed_valid) begin
         lfsr <= (seed == '0) ? lfsr_width'(1) : seed;
         gather <= '0;
         count <= '0;
      end else if (step) begin
         lfsr <= lfsr_step;
         gather <= gather_step;
         count <= word_done ? '0 : count + 1'b1;
      end

   // FIFO pointers and occupancy; seed load flushes and discards any pop
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         fill_level <= 2'd0;
      end else if (seed_valid) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         fill_level <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop) rd_ptr <= ~rd_ptr;
         fill_level <= fill_level + {1'b0, push} - {1'b0, pop};
      end

   // FIFO storage, written only on an accepted push
   always_ff @(posedge clk)
      if (push & ~seed_valid) mem[wr_ptr] <= push_data;
endmodule

// File: tb/tb_sr_rand_gen.sv
// tb_sr_rand_gen: directed stimulus with a queue-based reference model checked every cycle
module tb_sr_rand_gen;
   logic clk = 0, rst = 1, enable = 0, seed_valid = 0, rand_ready = 0;
   logic [31:0] seed = 0;
   logic rand_valid;
   logic [3:0] rand_out;
   logic [1:0] fill_level;
   int total = 0, bad = 0;

   sr_rand_gen dut (
      .clk(clk), .rst(rst), .enable(enable), .seed_valid(seed_valid), .seed(seed),
      .rand_valid(rand_valid), .rand_ready(rand_ready), .rand_out(rand_out), .fill_level(fill_level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   logic [31:0] m_lfsr;
   logic [3:0] m_q[$];
   logic [3:0] m_word;
   int m_bits;
   bit m_held;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_lfsr = 32'h1; m_q.delete(); m_word = 0; m_bits = 0; m_held = 0;
      end else if (seed_valid) begin
         m_lfsr = (seed == 0) ? 32'h1 : seed; m_q.delete(); m_word = 0; m_bits = 0; m_held = 0;
      end else begin
         if (rand_ready && m_q.size() > 0) void'(m_q.pop_front());
         if (m_held) begin
            if (m_q.size() < 2) begin
               m_q.push_back(m_word); m_word = 0; m_held = 0;
            end
         end else if (enable) begin
            m_word[m_bits] = m_lfsr[0];
            m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 32'h80200003) : (m_lfsr >> 1);
            m_bits++;
            if (m_bits == 4) begin
               m_bits = 0;
               if (m_q.size() < 2) begin
                  m_q.push_back(m_word); m_word = 0;
               end else m_held = 1;
            end
         end
      end
   end

   always @(negedge clk)
      if (!rst) begin
         chk("valid", rand_valid, m_q.size() != 0);
         chk("data", rand_out, m_q.size() != 0 ? m_q[0] : 4'h0);
         chk("fill", fill_level, m_q.size());
         chk("lfsr", dut.lfsr, m_lfsr);
      end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_valid", rand_valid, 0);
      chk("rst_out", rand_out, 0);
      chk("rst_fill", fill_level, 0);
      rst = 0; seed_valid = 1; seed = 1; enable = 1;
      @(negedge clk); seed_valid = 0;
      repeat (3) @(negedge clk);
      chk("s1_early", rand_valid, 0);
      @(negedge clk);
      chk("s1_valid", rand_valid, 1);
      chk("s1_word", rand_out, 4'hB);
      chk("s1_lfsr", dut.lfsr, 32'hB02C0003);
      repeat (4) @(negedge clk);
      chk("s2_fill", fill_level, 2);
      chk("s2_word", rand_out, 4'hB);
      repeat (6) @(negedge clk);
      chk("s2_hold_fill", fill_level, 2);
      chk("s2_hold_word", rand_out, 4'hB);
      rand_ready = 1;
      @(negedge clk); rand_ready = 0;
      chk("s3_fill", fill_level, 2);
      chk("s3_word", rand_out, 4'hD);
      repeat (6) @(negedge clk);
      rand_ready = 1; seed_valid = 1; seed = 0;
      @(negedge clk); seed_valid = 0; rand_ready = 0;
      chk("s4_fill", fill_level, 0);
      chk("s4_valid", rand_valid, 0);
      repeat (4) @(negedge clk);
      chk("s4_word", rand_out, 4'hB);
      chk("s4_lfsr", dut.lfsr, 32'hB02C0003);
      rand_ready = 1; seed_valid = 1; seed = 1;
      @(negedge clk); seed_valid = 0; rand_ready = 0;
      repeat (2) @(negedge clk);
      enable = 0;
      repeat (3) @(negedge clk);
      enable = 1;
      @(negedge clk);
      chk("s5_early", rand_valid, 0);
      @(negedge clk);
      chk("s5_valid", rand_valid, 1);
      chk("s5_word", rand_out, 4'hB);
      for (int i = 0; i < 40; i++) begin
         rand_ready = (i % 3 == 0);
         enable = (i % 5 != 0);
         @(negedge clk);
      end
      rand_ready = 0; enable = 1;
      repeat (8) @(negedge clk);
      chk("pre_rst_valid", rand_valid, 1);
      #2 rst = 1;
      #1;
      chk("ar_valid", rand_valid, 0);
      chk("ar_out", rand_out, 0);
      chk("ar_fill", fill_level, 0);
      @(negedge clk); rst = 0;
      repeat (3) @(negedge clk);
      chk("rr_early", rand_valid, 0);
      @(negedge clk);
      chk("rr_valid", rand_valid, 1);
      chk("rr_word", rand_out, 4'hB);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
